uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Transmit scheduler placed between the APB register block and uart_tx.
//  Buffers bytes written by software in a TX FIFO. Pops one byte per frame
//  and drives uart_tx's start_tx_i/tx_data_i handshake. Uses tx_done_o to
//  sequence back-to-back frames with no software involvement.
// PARAMETERS
//  DATA_W      8   width of one FIFO entry (UART character, max 8 bits)
//  FIFO_DEPTH  16  entries; power of two, >= 2; AW = $clog2(FIFO_DEPTH)
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        synchronous active-low reset
//  wr_en_i        in   1        push wr_data_i into FIFO this cycle
//  wr_data_i      in   DATA_W   byte to transmit
//  tx_en_i        in   1        1 = scheduler may start new frames
//  flush_i        in   1        1-cycle pulse: discard all FIFO contents
//  tx_done_i      in   1        from uart_tx tx_done_o (1 = transmitter idle)
//  start_tx_o     out  1        to uart_tx start_tx_i, 1-cycle pulse
//  tx_data_o      out  32       to uart_tx tx_data_i, byte zero-extended
//  fifo_full_o    out  1        count == FIFO_DEPTH
//  fifo_empty_o   out  1        count == 0
//  fifo_count_o   out  AW+1     current occupancy
//  wr_ovf_o       out  1        1-cycle pulse: write dropped (FIFO full)
//  busy_o         out  1        FSM not in IDLE
//  tx_cmplt_o     out  1        1-cycle pulse: frame finished on the line
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, pointers/count=0, start_tx_o=0,
//   tx_data_o=0, empty=1, full=0, wr_ovf_o=0, busy_o=0, tx_cmplt_o=0.
//   Reset mid-frame abandons the frame; no tx_cmplt_o is generated.
//  FIFO: circular buffer; rd/wr pointers wrap modulo FIFO_DEPTH; all flags
//   and count are registered and update in the cycle after the event.
//  Write: accepted if !full, or if full and a pop occurs in the same cycle
//   (count unchanged). Write when full with no pop: data dropped, wr_ovf_o=1.
//  Flush: resets pointers/count next cycle; has priority over a same-cycle
//   write (write dropped, no wr_ovf_o) and pop (no pop). Does not abort a
//   frame already handed to uart_tx.
//  FSM (start_tx_o = state==START; busy_o = state!=IDLE):
//   IDLE      -> START when tx_en_i & !empty & tx_done_i & !flush_i. Same
//                cycle: pop head; tx_data_o <= {zeros, head}.
//   START     -> WAIT_ACK unconditionally (start pulse is exactly 1 cycle).
//   WAIT_ACK  -> WAIT_DONE when tx_done_i==0 (uart_tx accepted request).
//   WAIT_DONE -> IDLE when tx_done_i==1; tx_cmplt_o=1 on that transition.
//  tx_data_o is held stable from the pop until the next pop.
//  Latency: write into an empty FIFO in IDLE (en=1, done=1) at cycle N gives
//   count=1 at N+1, pop at N+1, and start_tx_o=1 at N+2.
//  Back-to-back: after WAIT_DONE->IDLE, the next pop occurs in the first
//   IDLE cycle (one idle clk between frames at the sched level).
//  tx_en_i=0: no new pop; an in-flight frame runs to completion. Writes
//   are still accepted.
//  cts_n stall: uart_tx holds tx_done_o=0. The FSM waits in WAIT_DONE
//   without timeout.
//  Simultaneous write + pop with count==1: count stays 1, empty stays 0.
// TESTING
//  T1 reset, en=1, write 0xA5 -> start_tx_o 1 cycle at N+2,
//     tx_data_o=0x000000A5, tx_cmplt_o after model drops then raises done.
//  T2 write 16 bytes with en=0 -> full=1, count=16. 17th write -> wr_ovf_o
//     pulse; en=1 -> 16 frames in write order, empty=1 at end.
//  T3 FIFO full, en=1: pop coincides with a write of 0x3C -> write accepted,
//     count stays 16, 0x3C sent last.
//  T4 3 bytes queued, flush_i during frame 1 -> frame 1 completes
//     (tx_cmplt_o), no further start_tx_o, count=0.
//  T5 hold model tx_done_i=0 for 500 cycles after start -> FSM stays in
//     WAIT_DONE, busy_o=1, no second start; release -> next frame proceeds.
//  T6 rst_n=0 in WAIT_DONE with 4 bytes queued -> all outputs at reset
//     values next cycle, count=0, no tx_cmplt_o.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Bundle of signals between software-facing register logic, the TX
// scheduler and the uart_tx handshake. The master drives requests and the
// transmitter status; the slave is the scheduler itself.
interface uart_tx_sched_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              tx_en_i;
  logic              flush_i;
  logic              tx_done_i;
  logic              start_tx_o;
  logic [31:0]       tx_data_o;
  logic              fifo_full_o;
  logic              fifo_empty_o;
  logic [AW:0]       fifo_count_o;
  logic              wr_ovf_o;
  logic              busy_o;
  logic              tx_cmplt_o;

  modport master (
    output wr_en_i, wr_data_i, tx_en_i, flush_i, tx_done_i,
    input  start_tx_o, tx_data_o, fifo_full_o, fifo_empty_o,
           fifo_count_o, wr_ovf_o, busy_o, tx_cmplt_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, tx_en_i, flush_i, tx_done_i,
    output start_tx_o, tx_data_o, fifo_full_o, fifo_empty_o,
           fifo_count_o, wr_ovf_o, busy_o, tx_cmplt_o
  );
endinterface

// File: rtl/uart_tx_sched.sv
// TX scheduler: buffers software bytes in a circular FIFO and hands them to
// uart_tx one frame at a time, using tx_done to pace back-to-back frames.
module uart_tx_sched #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_sched_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              cmplt_q, cmplt_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              pop;
  logic              push;

  // Pop/push decisions; flush overrides both, a pop frees room for a write when full
  always_comb begin
    pop  = (state_q == IDLE) & bus.tx_en_i & ~empty_q & bus.tx_done_i & ~bus.flush_i;
    push = bus.wr_en_i & ~bus.flush_i & (~full_q | pop);
  end

  // Frame sequencing: launch on pop, wait for uart_tx to drop then raise done
  always_comb begin
    state_d = state_q;
    cmplt_d = 1'b0;
    case (state_q)
      IDLE:      if (pop) state_d = START;
      START:     state_d = WAIT_ACK;
      WAIT_ACK:  if (!bus.tx_done_i) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done_i) begin
                   state_d = IDLE;
                   cmplt_d = 1'b1;
                 end
      default:   state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy, registered flags and held output byte
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    ovf_d     = bus.wr_en_i & ~bus.flush_i & full_q & ~pop;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        tx_data_d = {{(32-DATA_W){1'b0}}, mem_q[rd_ptr_q]};
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
    full_d  = (count_d == (AW+1)'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data_i;
  end

  // State and control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      cmplt_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      cmplt_q   <= cmplt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.start_tx_o   = (state_q == START);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.tx_data_o    = tx_data_q;
  assign bus.fifo_full_o  = full_q;
  assign bus.fifo_empty_o = empty_q;
  assign bus.fifo_count_o = count_q;
  assign bus.wr_ovf_o     = ovf_q;
  assign bus.tx_cmplt_o   = cmplt_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic,
// with a queue-based scoreboard of bytes expected on the line and a
// behavioural uart_tx responder.
module tb_uart_tx_sched;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) ifc ();

  uart_tx_sched #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;
  int cmplt_cnt = 0;
  int ovf_cnt   = 0;
  int exp_ovf   = 0;
  logic [7:0] exp_q[$];
  bit long_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every start pulse must carry the oldest outstanding byte
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (ifc.start_tx_o === 1'b1) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: tx_data=%0h, no frame was outstanding", ifc.tx_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("frame_data", ifc.tx_data_o, {24'h0, e});
      end
    end
    if (ifc.tx_cmplt_o === 1'b1) cmplt_cnt++;
    if (ifc.wr_ovf_o === 1'b1) ovf_cnt++;
  end

  // Behavioural uart_tx: accept a start, go busy, later report idle again
  initial begin
    ifc.tx_done_i = 1'b1;
    forever begin
      @(negedge clk);
      if (ifc.start_tx_o === 1'b1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        ifc.tx_done_i = 1'b0;
        if (long_hold) repeat (500) @(negedge clk);
        else repeat ($urandom_range(4, 20)) @(negedge clk);
        ifc.tx_done_i = 1'b1;
      end
    end
  end

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (!(exp_q.size() == 0 && ifc.busy_o === 1'b0 && ifc.tx_done_i === 1'b1) && n < budget) begin
      tick;
      n++;
    end
    chk({nm, "_drain_in_time"}, 32'(n < budget), 32'd1);
    repeat (4) tick;
  endtask

  task automatic wait_low(input int budget, input string nm);
    int n = 0;
    while (ifc.tx_done_i !== 1'b0 && n < budget) begin
      tick;
      n++;
    end
    chk({nm, "_uart_busy_in_time"}, 32'(n < budget), 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    ifc.wr_en_i   = 1'b1;
    ifc.wr_data_i = b;
    exp_q.push_back(b);
    tick;
    ifc.wr_en_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_start"}, 32'(ifc.start_tx_o), 32'd0);
    chk({nm, "_tx_data"}, ifc.tx_data_o, 32'd0);
    chk({nm, "_empty"}, 32'(ifc.fifo_empty_o), 32'd1);
    chk({nm, "_full"}, 32'(ifc.fifo_full_o), 32'd0);
    chk({nm, "_count"}, 32'(ifc.fifo_count_o), 32'd0);
    chk({nm, "_ovf"}, 32'(ifc.wr_ovf_o), 32'd0);
    chk({nm, "_busy"}, 32'(ifc.busy_o), 32'd0);
    chk({nm, "_cmplt"}, 32'(ifc.tx_cmplt_o), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int c;
    ifc.wr_en_i   = 1'b0;
    ifc.wr_data_i = '0;
    ifc.tx_en_i   = 1'b0;
    ifc.flush_i   = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick;

    // T1: single byte, exact launch latency
    ifc.tx_en_i = 1'b1;
    write_byte(8'hA5);
    chk("t1_count_n1", 32'(ifc.fifo_count_o), 32'd1);
    chk("t1_start_n1", 32'(ifc.start_tx_o), 32'd0);
    tick;
    chk("t1_start_n2", 32'(ifc.start_tx_o), 32'd1);
    chk("t1_data_n2", ifc.tx_data_o, 32'h0000_00A5);
    chk("t1_busy_n2", 32'(ifc.busy_o), 32'd1);
    chk("t1_empty_n2", 32'(ifc.fifo_empty_o), 32'd1);
    tick;
    chk("t1_start_n3", 32'(ifc.start_tx_o), 32'd0);
    chk("t1_data_held", ifc.tx_data_o, 32'h0000_00A5);
    wait_drain(200, "t1");
    chk("t1_cmplt", 32'(cmplt_cnt), 32'd1);

    // T2: fill with scheduler disabled, overflow, then drain in order
    ifc.tx_en_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
    chk("t2_full", 32'(ifc.fifo_full_o), 32'd1);
    chk("t2_count", 32'(ifc.fifo_count_o), 32'd16);
    ifc.wr_en_i   = 1'b1;
    ifc.wr_data_i = 8'($urandom);
    tick;
    ifc.wr_en_i = 1'b0;
    exp_ovf++;
    chk("t2_ovf_pulse", 32'(ifc.wr_ovf_o), 32'd1);
    chk("t2_count_after_ovf", 32'(ifc.fifo_count_o), 32'd16);
    tick;
    chk("t2_ovf_clear", 32'(ifc.wr_ovf_o), 32'd0);
    s = start_cnt;
    ifc.tx_en_i = 1'b1;
    wait_drain(3000, "t2");
    chk("t2_frames", 32'(start_cnt - s), 32'd16);
    chk("t2_empty_end", 32'(ifc.fifo_empty_o), 32'd1);

    // T3: write while full in the same cycle as a pop
    ifc.tx_en_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
    ifc.tx_en_i = 1'b1;
    write_byte(8'h3C);
    chk("t3_count_stays", 32'(ifc.fifo_count_o), 32'd16);
    chk("t3_full_stays", 32'(ifc.fifo_full_o), 32'd1);
    chk("t3_no_ovf", 32'(ifc.wr_ovf_o), 32'd0);
    wait_drain(3000, "t3");

    // T4: flush during the first of three frames
    ifc.tx_en_i = 1'b0;
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    s = start_cnt;
    ifc.tx_en_i = 1'b1;
    wait_low(100, "t4");
    ifc.flush_i = 1'b1;
    exp_q.delete();
    tick;
    ifc.flush_i = 1'b0;
    chk("t4_count_flushed", 32'(ifc.fifo_count_o), 32'd0);
    chk("t4_empty_flushed", 32'(ifc.fifo_empty_o), 32'd1);
    chk("t4_busy_in_frame", 32'(ifc.busy_o), 32'd1);
    wait_drain(300, "t4");
    repeat (10) tick;
    chk("t4_one_frame", 32'(start_cnt - s), 32'd1);
    chk("t4_cmplt", 32'(cmplt_cnt), 32'(start_cnt));

    // T5: transmitter stalls (cts) for a long time
    long_hold = 1'b1;
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    wait_low(100, "t5");
    long_hold = 1'b0;
    s = start_cnt;
    c = 0;
    for (int i = 0; i < 450; i++) begin
      tick;
      if (ifc.busy_o !== 1'b1) c++;
    end
    chk("t5_busy_cycles_lost", 32'(c), 32'd0);
    chk("t5_no_second_start", 32'(start_cnt), 32'(s));
    wait_drain(1000, "t5");
    chk("t5_next_frame", 32'(start_cnt - s), 32'd1);
    chk("t5_cmplt", 32'(cmplt_cnt), 32'(start_cnt));

    // T6: reset while waiting for the transmitter with bytes queued
    long_hold     = 1'b1;
    ifc.tx_en_i = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    ifc.tx_en_i = 1'b1;
    wait_low(100, "t6");
    long_hold = 1'b0;
    chk("t6_busy_before", 32'(ifc.busy_o), 32'd1);
    chk("t6_count_before", 32'(ifc.fifo_count_o), 32'd4);
    rst_n = 1'b0;
    tick;
    check_reset_outputs("t6_reset");
    rst_n = 1'b1;
    exp_q.delete();
    s = start_cnt;
    c = cmplt_cnt;
    wait_drain(1000, "t6");
    chk("t6_no_cmplt", 32'(cmplt_cnt), 32'(c));
    chk("t6_no_start", 32'(start_cnt), 32'(s));

    // Randomized traffic with scheduler enable toggling
    for (int r = 0; r < 6; r++) begin
      c = cmplt_cnt;
      s = start_cnt;
      for (int k = 0; k < 60; k++) begin
        ifc.tx_en_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH) begin
          ifc.wr_en_i   = 1'b1;
          ifc.wr_data_i = 8'($urandom);
          exp_q.push_back(ifc.wr_data_i);
        end else begin
          ifc.wr_en_i = 1'b0;
        end
        tick;
      end
      ifc.wr_en_i = 1'b0;
      ifc.tx_en_i = 1'b1;
      wait_drain(4000, "rand");
      chk("rand_count_end", 32'(ifc.fifo_count_o), 32'd0);
      chk("rand_cmplt", 32'(cmplt_cnt - c), 32'(start_cnt - s));
    end

    chk("ovf_pulses", 32'(ovf_cnt), 32'(exp_ovf));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
